// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and default parameters for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_MAX = 4;

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker, searching from last_grant+1 upward with wrap
module rr_arb_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last_grant,
    output logic [IW-1:0]      o_pick,
    output logic               o_any_req
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    always_comb begin
        o_pick  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IW'((int'(i_last_grant) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                o_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter steering NUM_REQ requesters into one FIFO write port
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wr_data,
    input  logic                       fifo_full,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_grant_id;
    logic [IW-1:0] r_last_grant;
    logic [CW-1:0] r_burst_cnt;
    logic [IW-1:0] w_pick;
    logic          w_any;
    logic          w_act;
    logic          w_valid_g;
    logic          w_xfer;
    logic          w_last_xfer;

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick),
        .o_any_req    (w_any)
    );

    // Outputs are held quiet while rstn is low so a burst aborted by reset writes nothing
    assign w_act       = (r_state == GRANT) && rstn;
    assign w_valid_g   = req_valid[r_grant_id];
    assign w_xfer      = w_act && w_valid_g && !fifo_full;
    assign w_last_xfer = w_xfer && (r_burst_cnt == CW'(BURST_MAX - 1));

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_any ? GRANT : IDLE;
        else
            w_next = (!w_valid_g || w_last_xfer) ? IDLE : GRANT;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant_id   <= w_pick;
                r_last_grant <= w_pick;
                r_burst_cnt  <= '0;
            end else if (w_xfer && r_burst_cnt != CW'(BURST_MAX)) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        req_ready             = '0;
        req_ready[r_grant_id] = w_act && !fifo_full;
    end

    assign fifo_wr_en   = w_xfer;
    assign fifo_wr_data = w_xfer ? req_data[r_grant_id*WIDTH +: WIDTH] : '0;
    assign grant_id     = r_grant_id;
    assign busy         = w_act;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios for fifo_wr_arb against a depth-4 FIFO model
module tb_fifo_wr_arb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wr_data;
    logic           fifo_full;
    logic [1:0]     grant_id;
    logic           busy;

    logic           rd_en;
    logic           pre_wr;
    logic [7:0]     pre_data;
    int             fcnt = 0;
    logic [7:0]     fq[$];
    logic [7:0]     wlog[$];
    logic [7:0]     base[N];
    int             beat[N];
    int             total = 0;
    int             bad = 0;
    logic [15:0]    obs;

    always #5 clk = ~clk;

    fifo_wr_arb #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(B)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    assign fifo_full = (fcnt == 4);
    assign obs = {busy, fifo_wr_en, req_ready, grant_id, fifo_wr_data};

    always @(posedge clk) begin
        if (fifo_wr_en) begin
            fq.push_back(fifo_wr_data);
            wlog.push_back(fifo_wr_data);
        end
        if (pre_wr) fq.push_back(pre_data);
        if (rd_en && fcnt > 0) void'(fq.pop_front());
        fcnt <= fcnt + int'(fifo_wr_en) + int'(pre_wr) - int'(rd_en && fcnt > 0);
    end

    task automatic drive(input logic [N-1:0] v, input logic rd, input logic rs);
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) beat[i]++;
        @(posedge clk);
        #1;
        rstn      = rs;
        req_valid = v;
        rd_en     = rd;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = base[i] + 8'(beat[i]);
        #1;
    endtask

    task automatic clear_beats();
        for (int i = 0; i < N; i++) beat[i] = 0;
        wlog.delete();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'hF, 1'b0, 1'b0);
            total++; if (obs !== 16'h0000) begin bad++; $display("FAIL reset c=%0d obs=%h exp=%h", c, obs, 16'h0000); end
        end
        drive(4'h0, 1'b0, 1'b1);
        total++; if (obs !== 16'h0000) begin bad++; $display("FAIL reset_release obs=%h exp=%h", obs, 16'h0000); end
    endtask

    task automatic test_fairness();
        int seq[5] = '{0, 1, 2, 3, 0};
        logic [15:0] e;
        int k, pos, g, bt;
        clear_beats();
        for (int i = 0; i < N; i++) base[i] = {4'(i), 4'h0};
        for (int w = 0; w < 25; w++) begin
            drive(4'hF, 1'b1, 1'b1);
            k   = w / 5;
            pos = w % 5;
            if (pos == 0) begin
                e = {1'b0, 1'b0, 4'b0000, 2'((k == 0) ? 0 : seq[k-1]), 8'h00};
            end else begin
                g  = seq[k];
                bt = pos - 1 + ((k == 4) ? 4 : 0);
                e  = {1'b1, 1'b1, 4'(1 << g), 2'(g), 4'(g), 4'(bt)};
            end
            total++; if (obs !== e) begin bad++; $display("FAIL fairness w=%0d obs=%h exp=%h", w, obs, e); end
        end
        drive(4'h0, 1'b1, 1'b1);
        total++; if (obs !== 16'h0000) begin bad++; $display("FAIL fairness_end obs=%h exp=%h", obs, 16'h0000); end
        total++; if (wlog.size() !== 20) begin bad++; $display("FAIL fairness_count got=%0d exp=20", wlog.size()); end
    endtask

    task automatic test_single();
        logic [15:0] e;
        clear_beats();
        base[2] = 8'hA1;
        drive(4'b0100, 1'b1, 1'b1);
        total++; if (obs !== 16'h0000) begin bad++; $display("FAIL single_idle obs=%h exp=%h", obs, 16'h0000); end
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1, 1'b1);
            e = {1'b1, 1'b1, 4'b0100, 2'd2, 8'hA1 + 8'(i)};
            total++; if (obs !== e) begin bad++; $display("FAIL single_beat i=%0d obs=%h exp=%h", i, obs, e); end
        end
        drive(4'b0000, 1'b1, 1'b1);
        e = {1'b1, 1'b0, 4'b0100, 2'd2, 8'h00};
        total++; if (obs !== e) begin bad++; $display("FAIL single_drop obs=%h exp=%h", obs, e); end
        drive(4'b0000, 1'b1, 1'b1);
        e = {1'b0, 1'b0, 4'b0000, 2'd2, 8'h00};
        total++; if (obs !== e) begin bad++; $display("FAIL single_exit obs=%h exp=%h", obs, e); end
        total++; if (wlog.size() !== 3) begin bad++; $display("FAIL single_count got=%0d exp=3", wlog.size()); end
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            total++; if (wlog[i] !== 8'hA1 + 8'(i)) begin bad++; $display("FAIL single_order i=%0d got=%h exp=%h", i, wlog[i], 8'hA1 + 8'(i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        logic [15:0] exp_tab[8];
        logic        rd_tab[8];
        clear_beats();
        pre_wr   = 1'b1;
        pre_data = 8'hE0;
        drive(4'b0000, 1'b0, 1'b1);
        pre_data = 8'hE1;
        drive(4'b0000, 1'b0, 1'b1);
        pre_wr = 1'b0;
        base[1] = 8'h10;
        exp_tab = '{{1'b0, 1'b0, 4'b0000, 2'd2, 8'h00},
                    {1'b1, 1'b1, 4'b0010, 2'd1, 8'h10},
                    {1'b1, 1'b1, 4'b0010, 2'd1, 8'h11},
                    {1'b1, 1'b0, 4'b0000, 2'd1, 8'h00},
                    {1'b1, 1'b1, 4'b0010, 2'd1, 8'h12},
                    {1'b1, 1'b0, 4'b0000, 2'd1, 8'h00},
                    {1'b1, 1'b1, 4'b0010, 2'd1, 8'h13},
                    {1'b0, 1'b0, 4'b0000, 2'd1, 8'h00}};
        rd_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int w = 0; w < 8; w++) begin
            drive((w == 7) ? 4'b0000 : 4'b0010, rd_tab[w], 1'b1);
            e = exp_tab[w];
            total++; if (obs !== e) begin bad++; $display("FAIL backpressure w=%0d obs=%h exp=%h", w, obs, e); end
        end
        total++; if (fq.size() !== 4) begin bad++; $display("FAIL bp_fifo_level got=%0d exp=4", fq.size()); end
        for (int i = 0; i < 4 && i < fq.size(); i++) begin
            total++; if (fq[i] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, fq[i], 8'h10 + 8'(i)); end
        end
        for (int i = 0; i < 4; i++) drive(4'b0000, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] e;
        logic [7:0]  exp_log[3] = '{8'h30, 8'h31, 8'h05};
        clear_beats();
        base[3] = 8'h30;
        base[0] = 8'h05;
        drive(4'b1000, 1'b1, 1'b1);
        e = {1'b0, 1'b0, 4'b0000, 2'd1, 8'h00};
        total++; if (obs !== e) begin bad++; $display("FAIL rmid_idle obs=%h exp=%h", obs, e); end
        for (int i = 0; i < 2; i++) begin
            drive(4'b1000, 1'b1, 1'b1);
            e = {1'b1, 1'b1, 4'b1000, 2'd3, 8'h30 + 8'(i)};
            total++; if (obs !== e) begin bad++; $display("FAIL rmid_beat i=%0d obs=%h exp=%h", i, obs, e); end
        end
        drive(4'b1000, 1'b1, 1'b0);
        total++; if ({obs[15:10], obs[7:0]} !== 14'h0) begin bad++; $display("FAIL rmid_in_reset obs=%h exp=busy/wr/ready/data zero", obs); end
        drive(4'b1001, 1'b1, 1'b1);
        e = 16'h0000;
        total++; if (obs !== e) begin bad++; $display("FAIL rmid_after obs=%h exp=%h", obs, e); end
        drive(4'b1001, 1'b1, 1'b1);
        e = {1'b1, 1'b1, 4'b0001, 2'd0, 8'h05};
        total++; if (obs !== e) begin bad++; $display("FAIL rmid_regrant obs=%h exp=%h", obs, e); end
        drive(4'b0000, 1'b1, 1'b1);
        e = {1'b1, 1'b0, 4'b0001, 2'd0, 8'h00};
        total++; if (obs !== e) begin bad++; $display("FAIL rmid_drop obs=%h exp=%h", obs, e); end
        total++; if (wlog.size() !== 3) begin bad++; $display("FAIL rmid_count got=%0d exp=3", wlog.size()); end
        for (int i = 0; i < 3 && i < wlog.size(); i++) begin
            total++; if (wlog[i] !== exp_log[i]) begin bad++; $display("FAIL rmid_order i=%0d got=%h exp=%h", i, wlog[i], exp_log[i]); end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rd_en     = 1'b0;
        pre_wr    = 1'b0;
        pre_data  = '0;
        for (int i = 0; i < N; i++) begin
            base[i] = 8'hF0;
            beat[i] = 0;
        end
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters, legal range 2..8.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum number of words one grant may transfer, legal range 1..16.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit, the reset; it is synchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits, where bit i means requester i presents a word.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*WIDTH bits, where slice [i*WIDTH +: WIDTH] is requester i's word.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits, where bit i means requester i's word is accepted this cycle.
REQ-009 The block SHALL have port fifo_wr_en, output, 1 bit, the FIFO write strobe.
REQ-010 The block SHALL have port fifo_wr_data, output, WIDTH bits, the FIFO write data.
REQ-011 The block SHALL have port fifo_full, input, 1 bit, the FIFO full flag.
REQ-012 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits, the index of the current or last granted requester.
REQ-013 The block SHALL have port busy, output, 1 bit, which is high while in state GRANT.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-015 In IDLE with any req_valid bit high, the block SHALL pick the first valid requester in round-robin order starting at last_grant+1 (mod NUM_REQ), load grant_id and last_grant, clear burst_cnt and go to GRANT on the next edge.
REQ-016 In IDLE with all req_valid bits low, the block SHALL remain in IDLE.
REQ-017 In IDLE, req_ready SHALL be all zero and fifo_wr_en SHALL be 0.
REQ-018 In GRANT, req_ready[grant_id] SHALL equal !fifo_full, and all other req_ready bits SHALL be 0 (combinational).
REQ-019 In GRANT, fifo_wr_en SHALL equal req_valid[grant_id] && !fifo_full, and fifo_wr_data SHALL be the granted slice with zero added latency.
REQ-020 When fifo_wr_en is 0, fifo_wr_data SHALL be all zero.
REQ-021 Each accepted transfer (valid && ready) SHALL increment burst_cnt by 1, using a $clog2(BURST_MAX+1)-bit counter that never wraps.
REQ-022 GRANT SHALL exit to IDLE on the edge after a transfer that makes burst_cnt equal BURST_MAX.
REQ-023 GRANT SHALL exit to IDLE on any cycle in which req_valid[grant_id] is 0, whether or not fifo_full is high.
REQ-024 While fifo_full=1 and req_valid[grant_id]=1, the block SHALL hold the grant and burst_cnt with no timeout.
REQ-025 If the burst-limit condition and valid-drop coincide, the block SHALL go to IDLE exactly once.
REQ-026 Every GRANT to GRANT handover SHALL pass through exactly one IDLE cycle.
REQ-027 No word SHALL be written twice or lost: FIFO write order SHALL equal acceptance order.

Reset
REQ-028 When rstn=0 at a clock edge, the block SHALL set state=IDLE, burst_cnt=0, grant_id=0 and last_grant=NUM_REQ-1, so that requester 0 has first priority.
REQ-029 During and after reset, until the first grant, the outputs SHALL be req_ready=0, fifo_wr_en=0, fifo_wr_data=0 and busy=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst; the word presented in that cycle is not written.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum typedef (IDLE, GRANT) and default parameter constants.
REQ-032 Sub-module rr_arb_pick SHALL be a combinational round-robin picker with inputs req vector and last_grant, and outputs pick index and any_req.

Verification (WIDTH=8, NUM_REQ=4, BURST_MAX=4, FIFO DEPTH=4)
REQ-033 Reset: rstn=0 for 5 cycles with req_valid=4'b1111 -> fifo_wr_en=0, req_ready=0, busy=0 and grant_id=0 throughout.
REQ-034 Single requester: req 2 sends 8'hA1, 8'hA2, 8'hA3, then drops valid -> 1 IDLE cycle, grant_id=2, 3 consecutive writes; FIFO reads back A1, A2, A3.
REQ-035 Fairness: all 4 requesters continuously valid with data = {id, beat} -> grants 0, 1, 2, 3, 0, each of 4 beats, with one IDLE bubble between bursts; FIFO is drained every cycle.
REQ-036 Backpressure: FIFO preloaded with 2 words, req 1 sends 8'h10..8'h13 -> 2 writes, then full, req_ready[1]=0 and grant held; bench reads 1 word -> 8'h12 is written the following cycle; order is preserved.
REQ-037 Reset mid-burst: req 3 granted, rstn=0 after 2 beats -> next cycle IDLE with no write; after release with req 0 and req 3 valid, req 0 is granted first.
